// File: rtl/adc_align_pkg.sv
// Shared definitions for the ADC frame/word alignment block:
// alignment FSM encoding and error-counter sizing.
package adc_align_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } align_state_t;

  localparam int              ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

endpackage

// File: rtl/adc_frame_edge_det.sv
// Classifies the rising edge of the DDR frame signal into the half-cycle
// (phase 0 = rising-edge sample, phase 1 = falling-edge sample) it falls in.
module adc_frame_edge_det (
  input  logic dci,
  input  logic rst_n,
  input  logic f1,
  input  logic f2,
  output logic edge_p0,
  output logic edge_p1
);

  logic fp;

  // Starting high means a frame already asserted at reset release is not an edge.
  always_ff @(posedge dci or negedge rst_n) begin
    if (!rst_n) fp <= 1'b1;
    else        fp <= f2;
  end

  // The two classes need f1=1 and f1=0 respectively, so they never overlap.
  assign edge_p0 = ~fp & f1;
  assign edge_p1 = ~f1 & f2;

endmodule

// File: rtl/adc_word_align.sv
// Recovers NBITS-wide sample words from a DDR ADC bit stream by locking onto
// the frame signal, and reports lock status and lock-loss count.
module adc_word_align
  import adc_align_pkg::*;
#(
  parameter int NBITS  = 16,
  parameter int LOCK_N = 4
) (
  input  logic             dci,
  input  logic             rst_n,
  input  logic             q1,
  input  logic             q2,
  input  logic             f1,
  input  logic             f2,
  output logic [NBITS-1:0] dout,
  output logic             dvalid,
  output logic             locked,
  output logic             slip,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int W  = NBITS / 2;
  localparam int CW = $clog2(W + 1);
  localparam int GW = $clog2(LOCK_N + 1);

  align_state_t     state, state_nxt;
  logic [NBITS-1:0] hist;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [GW-1:0]    good, good_nxt;
  logic             phase_nxt;
  logic             edge_p0, edge_p1;
  logic             any_edge, good_edge, timeout;
  logic             emit, lose;
  logic [NBITS-1:0] word_sel;

  adc_frame_edge_det u_edge (
    .dci     (dci),
    .rst_n   (rst_n),
    .f1      (f1),
    .f2      (f2),
    .edge_p0 (edge_p0),
    .edge_p1 (edge_p1)
  );

  assign any_edge  = edge_p0 | edge_p1;
  assign good_edge = any_edge && (edge_p1 == slip) && (cnt == CW'(W - 1));
  assign timeout   = cnt == CW'(W);

  // Phase 1 words end on the current cycle's Q1, which is not yet in history.
  assign word_sel = slip ? {hist[NBITS-2:0], q1} : hist;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    phase_nxt = slip;
    cnt_nxt   = timeout ? cnt : cnt + CW'(1);
    emit      = 1'b0;
    lose      = 1'b0;
    unique case (state)
      ST_SEARCH: begin
        if (any_edge) begin
          state_nxt = ST_CONFIRM;
          phase_nxt = edge_p1;
          good_nxt  = GW'(1);
          cnt_nxt   = '0;
        end
      end
      ST_CONFIRM: begin
        if (good_edge) begin
          cnt_nxt  = '0;
          good_nxt = good + GW'(1);
          if (good_nxt == GW'(LOCK_N)) state_nxt = ST_LOCKED;
        end else if (any_edge || timeout) begin
          state_nxt = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (good_edge) begin
          cnt_nxt = '0;
          emit    = 1'b1;
        end else if (any_edge || timeout) begin
          // The offending edge is consumed here, never re-used by SEARCH.
          state_nxt = ST_SEARCH;
          lose      = 1'b1;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge dci or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SEARCH;
      hist    <= '0;
      cnt     <= '0;
      good    <= '0;
      slip    <= 1'b0;
      dout    <= '0;
      dvalid  <= 1'b0;
      locked  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state  <= state_nxt;
      hist   <= {hist[NBITS-3:0], q1, q2};
      cnt    <= cnt_nxt;
      good   <= good_nxt;
      slip   <= phase_nxt;
      dvalid <= emit;
      locked <= (state_nxt == ST_LOCKED);
      if (emit) dout <= word_sel;
      if (lose && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_word_align.sv
// Directed bench for adc_word_align (NBITS=16, LOCK_N=4): lock acquisition in
// both word phases, lock loss by early and missing frames, saturation, reset.
module tb_adc_word_align;

  localparam int NBITS = 16;

  logic             dci = 1'b0;
  logic             rst_n, q1, q2, f1, f2;
  logic [NBITS-1:0] dout;
  logic             dvalid, locked, slip;
  logic [7:0]       err_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          dv_cnt   = 0;
  int          dv_base;
  logic [15:0] dv_last  = '0;
  logic        cd = 1'b0, cf = 1'b0;

  adc_word_align #(.NBITS(NBITS), .LOCK_N(4)) dut (
    .dci     (dci),
    .rst_n   (rst_n),
    .q1      (q1),
    .q2      (q2),
    .f1      (f1),
    .f2      (f2),
    .dout    (dout),
    .dvalid  (dvalid),
    .locked  (locked),
    .slip    (slip),
    .err_cnt (err_cnt)
  );

  always #5 dci = ~dci;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One DCI cycle: drive, clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic a, input logic b, input logic fa, input logic fb);
    q1 = a; q2 = b; f1 = fa; f2 = fb;
    @(posedge dci);
    #1;
    if (dvalid === 1'b1) begin
      dv_cnt++;
      dv_last = dout;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Phase-0 word, cycles lo..hi; fr is the frame pattern over the 16 bit slots.
  task automatic wp0(input logic [15:0] w, input logic [15:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      cyc(w[15-2*i], w[14-2*i], fr[15-2*i], fr[14-2*i]);
  endtask

  task automatic word0(input logic [15:0] w, input logic [15:0] fr);
    wp0(w, fr, 0, 7);
  endtask

  // Stream delayed by one bit: Q1 carries the previous slot.
  task automatic word1(input logic [15:0] w, input logic [15:0] fr);
    logic a, fa;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin a = cd; fa = cf; end
      else begin a = w[16-2*i]; fa = fr[16-2*i]; end
      cyc(a, w[15-2*i], fa, fr[15-2*i]);
    end
    cd = w[0];
    cf = fr[0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q1 = 1'b0; q2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    repeat (2) @(posedge dci);
    @(negedge dci);
    rst_n = 1'b1;
  endtask

  // One forced loss: three/four good frames, then a frame one cycle early.
  task automatic lose_once();
    for (int i = 0; i < 4; i++) word0(16'hA5C3, 16'hFF00);
    word0(16'hA5C3, 16'hFF03);
  endtask

  initial begin
    rst_n = 1'b1;
    q1 = 1'b0; q2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_dout",   32'(dout),    32'h0);
    check("rst_dvalid", 32'(dvalid),  32'h0);
    check("rst_locked", 32'(locked),  32'h0);
    check("rst_slip",   32'(slip),    32'h0);
    check("rst_err",    32'(err_cnt), 32'h0);
    repeat (2) @(posedge dci);
    @(negedge dci);
    rst_n = 1'b1;

    // Phase-0 acquisition and emission.
    idle(1);
    for (int i = 0; i < 3; i++) word0(16'hA5C3, 16'hFF00);
    check("p0_lock_before_4th", 32'(locked), 32'h0);
    wp0(16'hA5C3, 16'hFF00, 0, 0);
    check("p0_lock_after_4th", 32'(locked), 32'h1);
    check("p0_no_dv_before_5th", 32'(dv_cnt), 32'd0);
    wp0(16'hA5C3, 16'hFF00, 1, 7);
    wp0(16'hA5C3, 16'hFF00, 0, 0);
    check("p0_dvalid_5th", 32'(dvalid), 32'h1);
    check("p0_dout_5th",   32'(dout),   32'hA5C3);
    check("p0_slip",       32'(slip),   32'h0);
    wp0(16'hA5C3, 16'hFF00, 1, 7);
    word0(16'h1234, 16'hFF00);
    word0(16'h0F0F, 16'hFF00);
    check("p0_dv_count", 32'(dv_cnt),  32'd3);
    check("p0_dout_1234", 32'(dv_last), 32'h1234);

    // Frame edge one cycle early while locked.
    wp0(16'hBEEF, 16'hFF03, 0, 6);
    check("early_still_locked", 32'(locked), 32'h1);
    wp0(16'hBEEF, 16'hFF03, 7, 7);
    check("early_unlocked", 32'(locked),  32'h0);
    check("early_err",      32'(err_cnt), 32'd1);
    check("early_last_word", 32'(dv_last), 32'h0F0F);
    dv_base = dv_cnt;
    for (int i = 0; i < 4; i++) word0(16'hA5C3, 16'hFF00);
    check("early_confirming", 32'(locked), 32'h0);
    wp0(16'hA5C3, 16'hFF00, 0, 0);
    check("early_relocked", 32'(locked), 32'h1);
    wp0(16'hA5C3, 16'hFF00, 1, 7);
    check("early_no_dv", 32'(dv_cnt - dv_base), 32'd0);
    wp0(16'hA5C3, 16'hFF00, 0, 0);
    check("early_dv_again", 32'(dv_cnt - dv_base), 32'd1);
    check("early_dout",     32'(dout), 32'hA5C3);
    wp0(16'hA5C3, 16'hFF00, 1, 7);

    // Frame held low while locked: loss when the count reaches 8.
    idle(1);
    check("gap_count7_locked", 32'(locked), 32'h1);
    idle(1);
    check("gap_unlocked", 32'(locked),  32'h0);
    check("gap_err",      32'(err_cnt), 32'd2);
    dv_base = dv_cnt;
    idle(18);
    for (int i = 0; i < 3; i++) word0(16'hA5C3, 16'hFF00);
    check("gap_not_yet", 32'(locked), 32'h0);
    word0(16'hA5C3, 16'hFF00);
    check("gap_relocked", 32'(locked), 32'h1);
    check("gap_dv_silent", 32'(dv_cnt - dv_base), 32'd0);

    // Error counter saturation.
    lose_once();
    check("sat_err_3", 32'(err_cnt), 32'd3);
    for (int i = 0; i < 252; i++) lose_once();
    check("sat_err_255", 32'(err_cnt), 32'd255);
    for (int i = 0; i < 47; i++) lose_once();
    check("sat_err_hold", 32'(err_cnt), 32'd255);
    check("sat_unlocked", 32'(locked),  32'h0);

    // Asynchronous reset mid-word while locked.
    for (int i = 0; i < 5; i++) word0(16'hA5C3, 16'hFF00);
    check("rst2_locked", 32'(locked), 32'h1);
    word0(16'hA5C3, 16'hFF00);
    wp0(16'hA5C3, 16'hFF00, 0, 3);
    check("rst2_dout_pre", 32'(dout), 32'hA5C3);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_dout",   32'(dout),    32'h0);
    check("rst2_dvalid", 32'(dvalid),  32'h0);
    check("rst2_locked_0", 32'(locked), 32'h0);
    check("rst2_slip",   32'(slip),    32'h0);
    check("rst2_err",    32'(err_cnt), 32'h0);
    repeat (2) @(posedge dci);
    @(negedge dci);
    rst_n = 1'b1;
    dv_base = dv_cnt;
    for (int i = 0; i < 5; i++) word0(16'hA5C3, 16'hFF00);
    check("rst2_relocked", 32'(locked), 32'h1);
    check("rst2_no_dv", 32'(dv_cnt - dv_base), 32'd0);
    wp0(16'hA5C3, 16'hFF00, 0, 0);
    check("rst2_dv_after_5", 32'(dv_cnt - dv_base), 32'd1);
    wp0(16'hA5C3, 16'hFF00, 1, 7);

    // CONFIRM timeout leaves ERR_CNT alone; then phase-1 acquisition.
    do_reset();
    idle(1);
    word0(16'hA5C3, 16'hFF00);
    word0(16'hA5C3, 16'hFF00);
    idle(12);
    check("confirm_abort_locked", 32'(locked),  32'h0);
    check("confirm_abort_err",    32'(err_cnt), 32'd0);
    cd = 1'b0; cf = 1'b0;
    word1(16'hA5C3, 16'hFF00);
    check("p1_slip", 32'(slip), 32'h1);
    for (int i = 0; i < 3; i++) word1(16'hA5C3, 16'hFF00);
    check("p1_locked", 32'(locked), 32'h1);
    dv_base = dv_cnt;
    word1(16'h3C5A, 16'hFF00);
    check("p1_dout_a5c3", 32'(dv_last), 32'hA5C3);
    word1(16'hA5C3, 16'hFF00);
    check("p1_dout_3c5a", 32'(dv_last), 32'h3C5A);
    word1(16'hA5C3, 16'hFF00);
    check("p1_dout_again", 32'(dv_last), 32'hA5C3);
    check("p1_dv_per_word", 32'(dv_cnt - dv_base), 32'd3);
    check("p1_slip_held", 32'(slip), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
